// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-access stage behind the ALU. Runs one data-memory
//            transaction per request over a valid/ready bus, formats store
//            data into byte lanes, and returns aligned, sign/zero-extended
//            load data to writeback. Misaligned/illegal accesses and bus
//            timeouts raise an exception without touching memory.
// Ports    : clk, rst                      - clock, async active-high reset
//            req_valid/ready/store/funct3/
//            addr/wdata/rd                 - request from execute stage
//            mem_valid/ready/we/addr/
//            wstrb/wdata/rvalid/rdata      - data-memory bus
//            wb_valid/rd/data              - load result to writeback
//            done, exc_valid/cause/addr    - completion and exception report
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_REQ  = 2'd1;
    localparam logic [1:0]  c_ST_WAIT = 2'd2;
    localparam logic [1:0]  c_ST_RESP = 2'd3;

    localparam logic [1:0]  c_CAUSE_LD_MISAL = 2'b00;
    localparam logic [1:0]  c_CAUSE_ST_MISAL = 2'b01;
    localparam logic [1:0]  c_CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0]  c_CAUSE_TIMEOUT  = 2'b11;

    localparam logic [16:0] c_TIMEOUT = 17'(TIMEOUT_CYCLES);

    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_mem_valid;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_done;
    logic        r_exc_valid;
    logic [1:0]  r_exc_cause;
    logic [31:0] r_exc_addr;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic [1:0]  w_err_cause;
    logic [31:0] w_fmt_wdata;
    logic [3:0]  w_fmt_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [16:0] w_cnt_inc;
    logic        w_timeout;

    assign req_ready = (r_state == c_ST_IDLE);
    assign w_accept  = req_valid && req_ready;

    // Counter is one bit wider so the compare can never wrap; ">=" also
    // covers a load whose handshake landed on the final allowed cycle.
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    assign w_timeout = (w_cnt_inc >= c_TIMEOUT);

    // Request checks; illegal width outranks misalignment.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_err_cause  = c_CAUSE_ILLEGAL;
        if (req_store) begin
            w_illegal = req_funct3[2] || (req_funct3 == 3'b011);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        if (!w_illegal) begin
            w_err_cause = req_store ? c_CAUSE_ST_MISAL : c_CAUSE_LD_MISAL;
        end
    end

    // Store lane replication and byte strobes.
    always_comb begin
        w_fmt_wdata = '0;
        w_fmt_wstrb = '0;
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    w_fmt_wdata = {4{req_wdata[7:0]}};
                    w_fmt_wstrb = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    w_fmt_wdata = {2{req_wdata[15:0]}};
                    w_fmt_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_fmt_wdata = req_wdata;
                    w_fmt_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Load lane extraction from the registered address and width.
    always_comb begin
        w_byte      = '0;
        w_load_data = mem_rdata;
        case (r_addr[1:0])
            2'b00: w_byte = mem_rdata[7:0];
            2'b01: w_byte = mem_rdata[15:8];
            2'b10: w_byte = mem_rdata[23:16];
            2'b11: w_byte = mem_rdata[31:24];
            default: w_byte = '0;
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rdata;
        endcase
        // x0 is hardwired zero; the access still happens on the bus.
        if (r_rd == 5'd0) begin
            w_load_data = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_funct3    <= '0;
            r_rd        <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_done      <= 1'b0;
            r_exc_valid <= 1'b0;
            r_exc_cause <= '0;
            r_exc_addr  <= '0;
        end else begin
            // Strobes are single-cycle: they are only set on entry to RESP.
            r_done      <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_exc_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr;
                        r_funct3 <= req_funct3;
                        r_rd     <= req_rd;
                        if (w_illegal || w_misaligned) begin
                            r_state     <= c_ST_RESP;
                            r_done      <= 1'b1;
                            r_exc_valid <= 1'b1;
                            r_exc_cause <= w_err_cause;
                            r_exc_addr  <= req_addr;
                        end else begin
                            r_state     <= c_ST_REQ;
                            r_cnt       <= '0;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= req_store;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_wstrb <= w_fmt_wstrb;
                            r_mem_wdata <= w_fmt_wdata;
                        end
                    end
                end
                c_ST_REQ: begin
                    // A completed handshake wins over a coincident timeout.
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_cnt       <= w_cnt_inc[15:0];
                        if (r_mem_we) begin
                            r_state <= c_ST_RESP;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end else if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= c_ST_RESP;
                        r_done      <= 1'b1;
                        r_exc_valid <= 1'b1;
                        r_exc_cause <= c_CAUSE_TIMEOUT;
                        r_exc_addr  <= r_addr;
                    end else begin
                        r_cnt <= w_cnt_inc[15:0];
                    end
                end
                c_ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_state    <= c_ST_RESP;
                        r_done     <= 1'b1;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_load_data;
                    end else if (w_timeout) begin
                        r_state     <= c_ST_RESP;
                        r_done      <= 1'b1;
                        r_exc_valid <= 1'b1;
                        r_exc_cause <= c_CAUSE_TIMEOUT;
                        r_exc_addr  <= r_addr;
                    end else begin
                        r_cnt <= w_cnt_inc[15:0];
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign done      = r_done;
    assign exc_valid = r_exc_valid;
    assign exc_cause = r_exc_cause;
    assign exc_addr  = r_exc_addr;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit: reset values,
//            store formatting, stalled and zero-wait loads, error reporting,
//            bus timeout, reset mid-transaction and loads to x0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TIMEOUT_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .done       (done),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_addr   (exc_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge; inputs driven here are sampled at
    // the following edge and outputs read here are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic store, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd);
        req_store  = store;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        req_valid  = 1'b1;
    endtask

    task automatic test_reset();
        logic [117:0] outs;
        rst = 1'b1;
        #1;
        outs = {mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, wb_valid,
                wb_rd, wb_data, done, exc_valid, exc_cause, exc_addr[31:22]};
        checks++;
        if (outs !== '0 || exc_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h / exc_addr %h want all zero", outs, exc_addr);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store(input string name, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_wstrb);
        mem_ready = 1'b1;
        issue(1'b1, f3, addr, wdata, 5'd0);
        tick();
        req_valid = 1'b0;
        checks++;
        if ({mem_valid, mem_we, req_ready, done} !== 4'b1100) begin
            errors++;
            $display("FAIL %s_req_phase got valid/we/ready/done %b%b%b%b want 1100",
                     name, mem_valid, mem_we, req_ready, done);
        end
        checks++;
        if (mem_addr !== exp_addr || mem_wstrb !== exp_wstrb || mem_wdata !== exp_wdata) begin
            errors++;
            $display("FAIL %s_bus got addr %h wstrb %b wdata %h want %h %b %h",
                     name, mem_addr, mem_wstrb, mem_wdata, exp_addr, exp_wstrb, exp_wdata);
        end
        tick();
        checks++;
        if ({done, wb_valid, exc_valid, mem_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_done got done/wb/exc/mvalid %b%b%b%b want 1000",
                     name, done, wb_valid, exc_valid, mem_valid);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({done, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_idle got done/ready %b%b want 01", name, done, req_ready);
        end
    endtask

    task automatic test_load_stall(input string name, input logic [2:0] f3,
                                   input logic [31:0] exp_data);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        issue(1'b0, f3, 32'h0000_2002, 32'hFFFF_FFFF, 5'd5);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_valid, mem_we, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'b0000, 32'h0000_2000}) begin
                errors++;
                $display("FAIL %s_stall%0d got valid %b we %b wstrb %b addr %h want 1 0 0000 00002000",
                         name, i, mem_valid, mem_we, mem_wstrb, mem_addr);
            end
            tick();
        end
        mem_ready = 1'b1;
        checks++;
        if ({mem_valid, mem_addr} !== {1'b1, 32'h0000_2000}) begin
            errors++;
            $display("FAIL %s_handshake got valid %b addr %h want 1 00002000", name, mem_valid, mem_addr);
        end
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12F0_3456;
        checks++;
        if ({mem_valid, wb_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL %s_wait got valid/wb/done %b%b%b want 000", name, mem_valid, wb_valid, done);
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        checks++;
        if ({wb_valid, done, exc_valid} !== 3'b110 || wb_data !== exp_data || wb_rd !== 5'd5) begin
            errors++;
            $display("FAIL %s_result got wb/done/exc %b%b%b data %h rd %0d want 110 %h 5",
                     name, wb_valid, done, exc_valid, wb_data, wb_rd, exp_data);
        end
        tick();
        checks++;
        if ({wb_valid, done, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL %s_after got wb/done/ready %b%b%b want 001", name, wb_valid, done, req_ready);
        end
    endtask

    task automatic test_error(input string name, input logic store, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [1:0] exp_cause);
        mem_ready = 1'b1;
        issue(store, f3, addr, 32'h1234_5678, 5'd1);
        tick();
        req_valid = 1'b0;
        checks++;
        if ({done, exc_valid, wb_valid, mem_valid, req_ready} !== 5'b11000 ||
            exc_cause !== exp_cause || exc_addr !== addr) begin
            errors++;
            $display("FAIL %s got done/exc/wb/mvalid/ready %b%b%b%b%b cause %b addr %h want 11000 %b %h",
                     name, done, exc_valid, wb_valid, mem_valid, req_ready, exc_cause, exc_addr,
                     exp_cause, addr);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({done, exc_valid, mem_valid, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL %s_after got done/exc/mvalid/ready %b%b%b%b want 0001",
                     name, done, exc_valid, mem_valid, req_ready);
        end
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_6000, 32'd0, 5'd3);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
            checks++;
            if ({mem_valid, exc_valid, done} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_pending%0d got mvalid/exc/done %b%b%b want 100",
                         i, mem_valid, exc_valid, done);
            end
            tick();
        end
        checks++;
        if ({exc_valid, done, mem_valid, wb_valid} !== 4'b1100 || exc_cause !== 2'b11 ||
            exc_addr !== 32'h0000_6000) begin
            errors++;
            $display("FAIL timeout_exc got exc/done/mvalid/wb %b%b%b%b cause %b addr %h want 1100 11 00006000",
                     exc_valid, done, mem_valid, wb_valid, exc_cause, exc_addr);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick();
        checks++;
        if ({wb_valid, done, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL timeout_stray1 got wb/done/ready %b%b%b want 001", wb_valid, done, req_ready);
        end
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if ({wb_valid, done, exc_valid} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_stray2 got wb/done/exc %b%b%b want 000", wb_valid, done, exc_valid);
        end
    endtask

    task automatic test_load_zero_wait(input string name, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [4:0] rd,
                                       input logic [31:0] rdata, input logic [31:0] exp_data);
        mem_ready = 1'b1;
        issue(1'b0, f3, addr, 32'd0, rd);
        tick();
        req_valid = 1'b0;
        checks++;
        if ({mem_valid, mem_we, req_ready} !== 3'b100 || mem_addr !== {addr[31:2], 2'b00}) begin
            errors++;
            $display("FAIL %s_req got mvalid/we/ready %b%b%b addr %h want 100 %h",
                     name, mem_valid, mem_we, req_ready, mem_addr, {addr[31:2], 2'b00});
        end
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        checks++;
        if ({mem_valid, done, wb_valid} !== 3'b000) begin
            errors++;
            $display("FAIL %s_wait got mvalid/done/wb %b%b%b want 000", name, mem_valid, done, wb_valid);
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        checks++;
        if ({wb_valid, done, exc_valid} !== 3'b110 || wb_data !== exp_data || wb_rd !== rd) begin
            errors++;
            $display("FAIL %s_result got wb/done/exc %b%b%b data %h rd %0d want 110 %h %0d",
                     name, wb_valid, done, exc_valid, wb_data, wb_rd, exp_data, rd);
        end
        tick();
        checks++;
        if ({wb_valid, done, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL %s_after got wb/done/ready %b%b%b want 001", name, wb_valid, done, req_ready);
        end
    endtask

    task automatic test_reset_mid_load();
        mem_ready = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd9);
        tick();
        req_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        // Now in WAIT; reset asynchronously between edges.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_valid, mem_we, mem_wstrb, wb_valid, done, exc_valid} !== 9'd0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0 || wb_data !== 32'd0 ||
            exc_addr !== 32'd0 || exc_cause !== 2'd0 || wb_rd !== 5'd0) begin
            errors++;
            $display("FAIL midreset_outputs got mvalid %b addr %h wb %b data %h done %b exc %b want all zero",
                     mem_valid, mem_addr, wb_valid, wb_data, done, exc_valid);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready got %b want 1", req_ready);
        end
        #1;
        rst = 1'b0;
        tick();
        test_load_zero_wait("lw_after_reset", 3'b010, 32'h0000_4000, 5'd9,
                            32'hDEAD_BEEF, 32'hDEAD_BEEF);
    endtask

    task automatic test_load_x0();
        test_load_zero_wait("lhu_x0", 3'b101, 32'h0000_5002, 5'd0, 32'hBEEF_1234, 32'h0000_0000);
        test_load_zero_wait("lh_x7",  3'b001, 32'h0000_5002, 5'd7, 32'hBEEF_1234, 32'hFFFF_BEEF);
        test_load_zero_wait("lbu_b1", 3'b100, 32'h0000_5001, 5'd2, 32'hBEEF_1234, 32'h0000_0012);
    endtask

    initial begin
        #2;
        test_reset();
        test_store("sb", 3'b000, 32'h0000_1003, 32'h0000_00A5,
                   32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
        test_store("sh", 3'b001, 32'h0000_1002, 32'h1234_ABCD,
                   32'h0000_1000, 32'hABCD_ABCD, 4'b1100);
        test_store("sw", 3'b010, 32'h0000_1004, 32'hCAFE_F00D,
                   32'h0000_1004, 32'hCAFE_F00D, 4'b1111);
        test_load_stall("lb",  3'b000, 32'hFFFF_FFF0);
        test_load_stall("lbu", 3'b100, 32'h0000_00F0);
        test_error("lw_misaligned", 1'b0, 3'b010, 32'h0000_3001, 2'b00);
        test_error("sh_misaligned", 1'b1, 3'b001, 32'h0000_3003, 2'b01);
        test_error("st_illegal",    1'b1, 3'b011, 32'h0000_3001, 2'b10);
        test_error("ld_illegal",    1'b0, 3'b110, 32'h0000_3000, 2'b10);
        test_timeout();
        test_reset_mid_load();
        test_load_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU. Takes the effective address that the ALU computed from rs1 + immediate, plus the store data and the load/store width. Runs one data-memory transaction over a valid/ready bus and returns load data, aligned and sign/zero-extended, to writeback. Misaligned or illegal accesses and bus timeouts are reported as exceptions without touching memory.

## Interface
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+WAIT before a bus-timeout exception (1..65535)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  unit can accept; high only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010
- req_addr  in  32  effective byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_we  out  1  write enable
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_wstrb  out  4  byte strobes; 0000 for loads
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle load result pulse
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- done  out  1  one-cycle pulse: access finished, with or without error
- exc_valid  out  1  one-cycle exception pulse, coincident with done
- exc_cause  out  2  00 load misaligned, 01 store misaligned, 10 illegal funct3, 11 bus timeout
- exc_addr  out  32  faulting req_addr

## Operation
- States: IDLE, REQ, WAIT, RESP.
- Accept: req_valid && req_ready, in IDLE. All request fields are registered on acceptance.
- Error checks at accept, in priority order:
  - illegal funct3 first: loads 011/110/111; stores 011–111
  - then misalignment: halfword addr[0] != 0; word addr[1:0] != 00
- On error: IDLE → RESP with exc; mem_valid is never asserted.
- Otherwise: IDLE → REQ.
- REQ:
  - mem_valid = 1, with mem_addr/mem_we/mem_wstrb/mem_wdata held stable until mem_ready.
  - On mem_valid && mem_ready: store → RESP; load → WAIT.
- WAIT:
  - mem_rvalid is sampled only in WAIT, never in the handshake cycle.
  - On mem_rvalid, capture the extracted data and go to RESP.
- RESP: lasts exactly one cycle. done = 1; wb_valid = 1 for successful loads; exc_valid = 1 on error. Then → IDLE.
- Store formatting:
  - SB: wdata = {4{b}}, wstrb = 0001 << addr[1:0]
  - SH: wdata = {2{h}}, wstrb = 0011 (addr[1]=0) or 1100
  - SW: wstrb = 1111
- Load extraction:
  - Byte lane = addr[1:0]; halfword = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Timeout:
  - A 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the count equals TIMEOUT_CYCLES: → RESP with cause 11, and mem_valid drops that same cycle.
  - mem_rvalid arriving in IDLE/RESP is ignored.
- rd = 0: the load is still performed and wb_valid still pulses; wb_data is forced to 0.

## Timing
- Reset (asynchronous, immediate): state IDLE; req_ready = 1; every other output 0, including mem_addr, wb_data, exc_addr, exc_cause.
- A reset mid-transaction drops mem_valid at once, with no pulse.
- Outputs are registered or state-decoded; there is no combinational path from req_* to mem_*.
- Accept at edge N, zero-wait bus:
  - mem_valid in cycle N+1
  - store: done in N+2
  - load: with mem_rvalid in N+2, wb_valid/done in N+3
- Error at accept N: exc_valid/done in N+1.
- req_ready is low from N+1 until the cycle after RESP; back-to-back accesses are therefore spaced by at least 3 cycles for stores and 4 for loads.
- wb_data/wb_rd/exc_* are valid only while their strobe is high. They hold their last value otherwise.

## Test plan
- Store SB:
  - Stimulus: addr 0x1003, wdata 0x000000A5, mem_ready = 1 immediately.
  - Required: mem_addr 0x1000, wstrb 1000, wdata 0xA5A5A5A5, we = 1; done 2 cycles after accept; no wb_valid.
- Load LB / LBU:
  - Stimulus: addr 0x2002, mem_rdata 0x12F0_3456, mem_ready held low 3 cycles.
  - Required: mem_valid stays high with stable outputs for those 3 cycles.
  - LB gives wb_data 0xFFFFFFF0; LBU gives 0x000000F0; wb_rd matches req_rd.
- Misaligned and illegal requests:
  - LW at 0x3001 → cause 00, exc_addr 0x3001, done at N+1, mem_valid never high.
  - SH at 0x3003 → cause 01.
  - Store funct3 011 at 0x3001 → cause 10 (illegal outranks misaligned).
- Bus timeout:
  - Stimulus: TIMEOUT_CYCLES = 4, load with mem_ready never asserted.
  - Required: exc cause 11 pulses with mem_valid dropping; a later stray mem_rvalid produces no wb_valid.
- Reset mid-load:
  - Stimulus: assert rst in WAIT.
  - Required: all outputs 0 and req_ready 1 without waiting for a clock edge; the next LW at 0x4000 with rdata 0xDEADBEEF returns 0xDEADBEEF.
- Load to x0:
  - Stimulus: LHU rd = 0 at 0x5002, rdata 0xBEEF1234.
  - Required: wb_valid = 1, wb_data 0.
  - With rd = 7 instead, LH gives 0xFFFFBEEF.
